// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for a word-organised, little-endian data
// memory. Handles byte/half/word loads and stores over valid/ready handshakes;
// sub-word stores are performed as read-modify-write.
module load_store_unit #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [2:0]  req_bytes;
  logic [32:0] req_end;
  logic        req_err;

  // Select the addressed lane of a memory word and sign/zero-extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of a memory word with right-justified store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) r[{lane, 3'b000} +: 8] = wdata[7:0];
    else               r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    return r;
  endfunction

  // Classify the incoming request: reserved size, misalignment or out of range.
  // The end address is formed one bit wider so huge addresses cannot wrap.
  always_comb begin
    case (req_size_i)
      2'b00:   req_bytes = 3'd1;
      2'b01:   req_bytes = 3'd2;
      default: req_bytes = 3'd4;
    endcase
    req_end = {1'b0, req_addr_i} + {30'h0, req_bytes};
    req_err = (req_size_i == 2'b11)
           || ((req_size_i == 2'b01) && req_addr_i[0])
           || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))
           || (req_end > 33'(MEM_BYTES));
  end

  // State register; reset drops straight back to IDLE, aborting any write.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request fields, load result and store word. Outputs are gated by state,
  // so these need no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && req_valid_i) begin
      we_q    <= req_we_i;
      size_q  <= req_size_i;
      uns_q   <= req_unsigned_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      err_q   <= req_err;
      rdata_q <= 32'h0;
    end else if (state_q == READ) begin
      if (!we_q) rdata_q <= extend_load(mem_data_i, addr_q[1:0], size_q, uns_q);
      else       wdata_q <= merge_store(mem_data_i, wdata_q, addr_q[1:0], size_q);
    end
  end

  // Next-state and output decode; outputs are zero outside their owning state.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = 32'h0;
    resp_err_o   = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = 32'h0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (req_err)                              state_d = RESP;
          else if (!req_we_i || req_size_i != 2'b10) state_d = READ;
          else                                       state_d = WRITE;
        end
      end
      READ: begin
        mem_read_o = 1'b1;
        mem_addr_o = {addr_q[31:2], 2'b00};
        state_d    = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_write_o = 1'b1;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_data_o  = wdata_q;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = rdata_q;
        resp_err_o   = err_q;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: behavioural 128-byte memory, byte-level
// reference model, directed scenarios plus randomized accesses.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_data_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i)
  );

  // Data memory: 32 words, combinational read, write on rising edge.
  logic [31:0] mem [0:31];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_idx = 5'd0;
  logic [31:0] pre_data = 32'h0;

  always @(posedge clk_i) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_write_o && mem_addr_o < 32'd128) mem[mem_addr_o[6:2]] <= mem_data_o;
  end

  assign mem_data_i = (mem_addr_o < 32'd128) ? mem[mem_addr_o[6:2]] : 32'h0;

  // Reference model: the memory as a flat array of bytes.
  logic [7:0] ref_mem [0:127];

  function automatic int acc_bytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
    int n;
    longint last;
    n = acc_bytes(size);
    if (size == 2'd3) return 1'b1;
    if ((addr % n) != 0) return 1'b1;
    last = longint'({32'h0, addr}) + n;
    return last > 128;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
    int n;
    int a;
    longint v;
    n = acc_bytes(size);
    a = int'(addr[6:0]);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[a + i]) << (8 * i));
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic void ref_store(input logic [1:0] size, input logic [31:0] addr,
                                    input logic [31:0] wdata);
    int a;
    a = int'(addr[6:0]);
    for (int i = 0; i < acc_bytes(size); i++) ref_mem[a + i] = 8'(wdata >> (8 * i));
  endfunction

  function automatic logic [31:0] ref_word(input int base);
    return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
  endfunction

  task automatic preload(input logic [6:0] waddr, input logic [31:0] w);
    int base;
    base = int'(waddr) & 32'h7C;
    @(negedge clk_i);
    pre_we = 1'b1; pre_idx = waddr[6:2]; pre_data = w;
    @(posedge clk_i);
    #1 pre_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[base + i] = w[8 * i +: 8];
  endtask

  // Drive one request, observe it through to the consumed response.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input logic junk,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int nrd, output int nwr, output int rd_at, output int wr_at,
                         output logic [31:0] wr_word, output int bad, output int unstable);
    lat = -1; rdata = 32'h0; err = 1'b0; nrd = 0; nwr = 0; rd_at = -1; wr_at = -1;
    wr_word = 32'h0; bad = 0; unstable = 0;
    @(negedge clk_i);
    if (req_ready_o !== 1'b1) bad++;
    req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (mem_read_o) begin nrd++; rd_at = c; end
      if (mem_write_o) begin nwr++; wr_at = c; wr_word = mem_data_o; end
      if (mem_read_o && mem_write_o) bad++;
      if (mem_read_o || mem_write_o) begin
        if (mem_addr_o !== {addr[31:2], 2'b00}) bad++;
      end else if (mem_addr_o !== 32'h0 || mem_data_o !== 32'h0) bad++;
      if (req_ready_o !== 1'b0) bad++;
      if (resp_valid_o === 1'b1) begin
        lat = c; rdata = resp_rdata_o; err = resp_err_o;
        break;
      end
    end
    if (lat < 0) return;
    for (int h = 0; h < hold; h++) begin
      resp_ready_i = 1'b0;
      if (junk) req_valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      if (resp_valid_o !== 1'b1 || resp_rdata_o !== rdata || resp_err_o !== err ||
          req_ready_o !== 1'b0 || mem_read_o !== 1'b0 || mem_write_o !== 1'b0) unstable++;
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 resp_ready_i = 1'b0; req_valid_i = 1'b0;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) unstable++;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_tests++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'h0 ||
        resp_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
               req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o);
    end
    n_tests++;
    if (mem_read_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h0 ||
        mem_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%h data=%h, required all 0",
               mem_read_o, mem_write_o, mem_addr_o, mem_data_o);
    end
    rst_i = 1'b1;
    for (int w = 0; w < 32; w++) preload(7'(w * 4), $urandom);
  endtask

  task automatic test_loads();
    logic [31:0] rd, ww;
    logic e;
    int lat, nrd, nwr, rda, wra, bad, uns_cnt;
    logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h11, 32'h11, 32'h12, 32'h12};
    logic [31:0] ex [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};
    preload(7'h10, 32'h8899AABB);
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, sz[i], un[i], ad[i], 32'h0, 0, 1'b0,
              lat, rd, e, nrd, nwr, rda, wra, ww, bad, uns_cnt);
      n_tests++;
      if (lat !== 2 || rd !== ex[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL load_%0d: lat=%0d rdata=%h err=%b, required lat=2 rdata=%h err=0",
                 i, lat, rd, e, ex[i]);
      end
      n_tests++;
      if (nrd !== 1 || rda !== 1 || nwr !== 0 || bad !== 0 || uns_cnt !== 0) begin
        n_fail++;
        $display("FAIL load_strobes_%0d: reads=%0d@%0d writes=%0d bad=%0d unstable=%0d, required 1@1 0 0 0",
                 i, nrd, rda, nwr, bad, uns_cnt);
      end
    end
  endtask

  task automatic test_sub_store();
    logic [31:0] rd, ww;
    logic e;
    int lat, nrd, nwr, rda, wra, bad, uns_cnt;
    preload(7'h10, 32'h8899AABB);
    run_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h12345677, 0, 1'b0,
            lat, rd, e, nrd, nwr, rda, wra, ww, bad, uns_cnt);
    ref_store(2'd0, 32'h13, 32'h12345677);
    n_tests++;
    if (lat !== 3 || rd !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_resp: lat=%0d rdata=%h err=%b, required lat=3 rdata=0 err=0", lat, rd, e);
    end
    n_tests++;
    if (rda !== 1 || wra !== 2 || nrd !== 1 || nwr !== 1 || ww !== 32'h7799AABB || bad !== 0) begin
      n_fail++;
      $display("FAIL sb_rmw: read@%0d write@%0d data=%h bad=%0d, required read@1 write@2 data=7799aabb",
               rda, wra, ww, bad);
    end
    n_tests++;
    if (mem[4] !== 32'h7799AABB) begin
      n_fail++;
      $display("FAIL sb_memory: word 0x10=%h, required 7799aabb", mem[4]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, ww;
    logic e;
    int lat, nrd, nwr, rda, wra, bad, uns_cnt, diff;
    logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] ad [4] = '{32'h11, 32'h12, 32'h00, 32'h80};
    for (int i = 0; i < 4; i++) begin
      run_req(we[i], sz[i], 1'b0, ad[i], 32'hCAFEF00D, 0, 1'b0,
              lat, rd, e, nrd, nwr, rda, wra, ww, bad, uns_cnt);
      n_tests++;
      if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || nrd !== 0 || nwr !== 0 || bad !== 0) begin
        n_fail++;
        $display("FAIL error_%0d: lat=%0d err=%b rdata=%h reads=%0d writes=%0d bad=%0d, required lat=1 err=1 rdata=0 no access",
                 i, lat, e, rd, nrd, nwr, bad);
      end
    end
    diff = 0;
    for (int w = 0; w < 32; w++) if (mem[w] !== ref_word(w * 4)) diff++;
    n_tests++;
    if (diff !== 0) begin
      n_fail++;
      $display("FAIL error_memory: %0d words changed, required 0", diff);
    end
  endtask

  task automatic test_word_store_stall();
    logic [31:0] rd, ww;
    logic e;
    int lat, nrd, nwr, rda, wra, bad, uns_cnt;
    run_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 5, 1'b1,
            lat, rd, e, nrd, nwr, rda, wra, ww, bad, uns_cnt);
    ref_store(2'd2, 32'h20, 32'hDEADBEEF);
    n_tests++;
    if (lat !== 2 || rd !== 32'h0 || e !== 1'b0 || nrd !== 0 || nwr !== 1 || wra !== 1 ||
        ww !== 32'hDEADBEEF || bad !== 0) begin
      n_fail++;
      $display("FAIL sw_write: lat=%0d err=%b reads=%0d write@%0d data=%h bad=%0d, required lat=2 no read write@1 deadbeef",
               lat, e, nrd, wra, ww, bad);
    end
    n_tests++;
    if (uns_cnt !== 0) begin
      n_fail++;
      $display("FAIL sw_stall_stable: %0d unstable cycles, required 0", uns_cnt);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 1'b0,
            lat, rd, e, nrd, nwr, rda, wra, ww, bad, uns_cnt);
    n_tests++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || e !== 1'b0 || bad !== 0) begin
      n_fail++;
      $display("FAIL lw_after_sw: lat=%0d rdata=%h err=%b, required lat=2 deadbeef err=0", lat, rd, e);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, ww, addr, wdata, exp_rd, exp_ww;
    logic [1:0] size;
    logic we, uns, e, exp_e;
    int lat, nrd, nwr, rda, wra, bad, uns_cnt, exp_lat, exp_nrd, exp_nwr, diff;
    for (int it = 0; it < 60; it++) begin
      addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 131));
      size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % acc_bytes(size));
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      wdata = $urandom;
      exp_e = ref_err(size, addr);
      exp_rd = 32'h0; exp_ww = 32'h0;
      if (exp_e) begin
        exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
      end else if (!we) begin
        exp_lat = 2; exp_nrd = 1; exp_nwr = 0; exp_rd = ref_load(size, uns, addr);
      end else begin
        exp_lat = (size == 2'd2) ? 2 : 3;
        exp_nrd = (size == 2'd2) ? 0 : 1;
        exp_nwr = 1;
        ref_store(size, addr, wdata);
        exp_ww = ref_word(int'(addr[6:2]) * 4);
      end
      run_req(we, size, uns, addr, wdata, $urandom_range(0, 2), 1'b0,
              lat, rd, e, nrd, nwr, rda, wra, ww, bad, uns_cnt);
      n_tests++;
      if (lat !== exp_lat || rd !== exp_rd || e !== exp_e) begin
        n_fail++;
        $display("FAIL rand_resp_%0d: we=%b size=%0d addr=%h lat=%0d rdata=%h err=%b, required lat=%0d rdata=%h err=%b",
                 it, we, size, addr, lat, rd, e, exp_lat, exp_rd, exp_e);
      end
      n_tests++;
      if (nrd !== exp_nrd || nwr !== exp_nwr || ww !== exp_ww || bad !== 0 || uns_cnt !== 0) begin
        n_fail++;
        $display("FAIL rand_mem_%0d: reads=%0d writes=%0d data=%h bad=%0d unstable=%0d, required %0d %0d %h 0 0",
                 it, nrd, nwr, ww, bad, uns_cnt, exp_nrd, exp_nwr, exp_ww);
      end
    end
    diff = 0;
    for (int w = 0; w < 32; w++) if (mem[w] !== ref_word(w * 4)) diff++;
    n_tests++;
    if (diff !== 0) begin
      n_fail++;
      $display("FAIL rand_memory: %0d words differ from reference, required 0", diff);
    end
  endtask

  task automatic test_reset_mid_write();
    int stray;
    preload(7'h04, 32'h11223344);
    @(negedge clk_i);
    req_we_i = 1'b1; req_size_i = 2'd0; req_unsigned_i = 1'b0;
    req_addr_i = 32'h04; req_wdata_i = 32'h000000AB; req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(posedge clk_i);
    #2;
    n_tests++;
    if (mem_write_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_write: mem_write_o=%b, required 1", mem_write_o);
    end
    rst_i = 1'b0;
    #1;
    n_tests++;
    if (mem_write_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_async: wr=%b addr=%h data=%h, required 0 0 0",
               mem_write_o, mem_addr_o, mem_data_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_tests++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'h0 ||
        resp_err_o !== 1'b0 || mem_read_o !== 1'b0 || mem_write_o !== 1'b0 ||
        mem_addr_o !== 32'h0 || mem_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_release: ready=%b valid=%b rdata=%h err=%b rd=%b wr=%b, required 1 0 0 0 0 0",
               req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, mem_read_o, mem_write_o);
    end
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (resp_valid_o !== 1'b0 || mem_write_o !== 1'b0) stray++;
    end
    n_tests++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL abort_no_resp: %0d cycles with response or write, required 0", stray);
    end
    n_tests++;
    if (mem[1] !== 32'h11223344) begin
      n_fail++;
      $display("FAIL abort_memory: word 0x04=%h, required 11223344", mem[1]);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sub_store();
    test_errors();
    test_word_store_stall();
    test_random();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator for the pipelined CPU's word-organised, little-endian data memory (128 bytes, combinational read, write on rising clock edge). Accepts byte, halfword and word load/store requests from the pipeline over a valid/ready handshake. Drives the memory's address, write-data, read-enable and write-enable pins, performing sub-word stores as read-modify-write. Returns aligned, sign- or zero-extended load data and an error flag through a response handshake.

## Interface
- MEM_BYTES, 128, data memory size in bytes; addresses >= MEM_BYTES are errors
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request (high only in IDLE)
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (error)
- req_unsigned_i  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid_o  out  1  response present
- resp_ready_i  in  1  pipeline consumes response
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_err_o  out  1  misaligned, out-of-range or reserved-size request
- mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- mem_data_o  out  32  write data to memory
- mem_read_o  out  1  memory read enable
- mem_write_o  out  1  memory write enable
- mem_data_i  in  32  memory read data (valid in the same cycle as mem_addr_o/mem_read_o)

## Operation
- States: IDLE, READ, WRITE, RESP. Reset value: IDLE.
- Reset values: all outputs 0, except req_ready_o = 1 (IDLE).
- IDLE: req_ready_o = 1. On req_valid_i, latch all req_* fields.
  - Request is an error if any of these holds: size = 11; half with addr[0] = 1; word with addr[1:0] != 0; addr + access bytes > MEM_BYTES.
  - Error -> RESP with err = 1. No memory access.
  - Load or sub-word store -> READ.
  - Word store -> WRITE.
- READ: mem_read_o = 1, mem_addr_o = aligned address. Capture mem_data_i at the clock edge.
  - Load -> RESP. rdata = selected lane, extended.
    - Byte lane k = addr[1:0], bits [8k+7:8k].
    - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
  - Sub-word store -> WRITE. Merged word = captured word with the addressed lane(s) replaced by req_wdata.
- WRITE: mem_write_o = 1, mem_addr_o = aligned address, mem_data_o = merged or full word. -> RESP.
- RESP: resp_valid_o = 1 with resp_rdata_o and resp_err_o held stable. On resp_ready_i -> IDLE.
- Outside READ/WRITE: mem_read_o = mem_write_o = 0 and mem_addr_o = mem_data_o = 0. Memory strobes are never both high.
- Stores return resp_rdata_o = 0, err = 0.

## Timing
- Cycle 0 is the request-accept edge. resp_valid_o first asserts in:
  - cycle 2 for loads and word stores;
  - cycle 3 for sub-word stores;
  - cycle 1 for errors.
- The memory commits the write at the rising edge that ends the WRITE cycle.
- resp_ready_i high in the first RESP cycle gives a throughput of one access per 3 cycles (4 for sub-word stores).
- resp_ready_i low holds RESP indefinitely with outputs stable. No new request is accepted; req_ready_o = 0.
- req_valid_i is sampled only in IDLE. Requests presented in other states are not consumed.
- Reset asserted mid-operation immediately returns to IDLE and forces outputs to their reset values.
  - During WRITE, mem_write_o falls asynchronously, so the write is aborted.
  - No response is produced for the aborted request.

## Test plan
- Preload word 0x10 = 0x8899AABB. lb signed @0x11 -> resp_rdata_o = 0xFFFFFFAA in cycle 2, err = 0. lbu @0x11 -> 0x000000AA.
- Preload word 0x10 = 0x8899AABB. lh signed @0x12 -> 0xFFFF8899. lhu @0x12 -> 0x00008899. Exactly one mem_read_o cycle, no mem_write_o.
- Preload word 0x10 = 0x8899AABB. sb @0x13, wdata 0x12345677 -> READ cycle 1, WRITE cycle 2 with mem_data_o = 0x7799AABB, resp_valid_o cycle 3. Memory word 0x10 = 0x7799AABB afterwards.
- sh @0x11, lw @0x12, size 11 @0x00, and lw @0x80 -> each gives resp_err_o = 1 in cycle 1. mem_read_o/mem_write_o never assert. Memory is unchanged.
- sw @0x20, data 0xDEADBEEF, with resp_ready_i held low 5 cycles -> write in cycle 1, resp_valid_o stable cycles 2–7, req_ready_o = 0 throughout. Back-to-back lw @0x20 then returns 0xDEADBEEF.
- sb @0x04 with rst_i pulled low during WRITE -> mem_write_o drops immediately, no response, word 0x04 unchanged. After release, req_ready_o = 1 and all other outputs are 0.
